spi_slave: RTL

- SPI slave (target) endpoint. It is the far end of the team's SPI master and supports the same CPOL/CPHA modes and the same LSB-first bit order.
- Inputs sck_i, ss_i and mosi_i are sampled in the clk_i domain through 2-flop synchronizers. Edge detection and data shifting are done in clk_i; no logic is clocked from sck.
- Provides a one-word transmit holding register toward the fabric, a received-word strobe, and error flags.
- Sits at the FPGA pins facing an external SPI master.

---
 rtl/spi_slave.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : SPI target endpoint; SCK/SS/MOSI are synchronized and processed
//            entirely in the clk_i domain. LSB-first, all four CPOL/CPHA modes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic                 sck_i,
    input  logic                 ss_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    output logic                 miso_oe_o,
    input  logic [DATA_SIZE-1:0] txdata_i,
    input  logic                 tx_wr_i,
    output logic                 tx_full_o,
    output logic [DATA_SIZE-1:0] rxdata_o,
    output logic                 rx_valid_o,
    output logic                 busy_o,
    output logic                 underrun_o,
    output logic                 frame_err_o
);

    localparam int c_CNT_W = $clog2(DATA_SIZE);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_sck_meta, r_sck_sync, r_sck_prev;
    logic                   r_ss_meta, r_ss_sync, r_ss_prev;
    logic                   r_mosi_meta, r_mosi_sync;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [DATA_SIZE-1:0]   r_tx_shift;
    logic [DATA_SIZE-1:0]   r_rx_shift;
    logic [DATA_SIZE-1:0]   r_hold;
    logic                   r_tx_full;
    logic [DATA_SIZE-1:0]   r_rxdata;
    logic                   r_rx_valid;
    logic                   r_oe;
    logic                   r_busy;
    logic                   r_underrun;
    logic                   r_ur_pend;
    logic                   r_frame_err;

    logic                   w_sck_lead, w_sck_trail, w_sample, w_shift;
    logic                   w_ss_fall, w_run, w_first, w_last_sample;
    logic                   w_reload, w_tx_step;
    logic [DATA_SIZE-1:0]   w_rx_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sck_meta  <= cpol_i;
            r_sck_sync  <= cpol_i;
            r_sck_prev  <= cpol_i;
            r_ss_meta   <= 1'b1;
            r_ss_sync   <= 1'b1;
            r_ss_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sck_meta  <= sck_i;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_ss_meta   <= ss_i;
            r_ss_sync   <= r_ss_meta;
            r_ss_prev   <= r_ss_sync;
            r_mosi_meta <= mosi_i;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sck_lead    = (r_sck_prev == cpol_i) && (r_sck_sync != cpol_i);
    assign w_sck_trail   = (r_sck_prev != cpol_i) && (r_sck_sync == cpol_i);
    assign w_sample      = cpha_i ? w_sck_trail : w_sck_lead;
    assign w_shift       = cpha_i ? w_sck_lead  : w_sck_trail;
    assign w_ss_fall     = r_ss_prev & ~r_ss_sync;
    assign w_run         = (r_state == ST_ACTIVE) && !r_ss_sync;
    assign w_first       = (r_bit_cnt == '0);
    assign w_last_sample = w_sample && (r_bit_cnt == c_LAST);
    assign w_rx_next     = {r_mosi_sync, r_rx_shift[DATA_SIZE-1:1]};

    // cpha=0 reloads on the trailing edge that closes a word (count already
    // wrapped to 0); cpha=1 reloads on the closing sample and then skips the
    // first leading shift so bit 0 stays on the line.
    assign w_reload  = (r_state == ST_LOAD) ||
                       (w_run && (cpha_i ? w_last_sample : (w_shift && w_first)));
    assign w_tx_step = w_run && w_shift && !w_first;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_hold      <= '0;
            r_tx_full   <= 1'b0;
            r_rxdata    <= '0;
            r_rx_valid  <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
            r_ur_pend   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            if (tx_wr_i) begin
                r_hold    <= txdata_i;
                r_tx_full <= 1'b1;
                if (!r_busy) begin
                    r_underrun <= 1'b0;
                end
            end else if (w_reload) begin
                r_tx_full <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state <= ST_LOAD;
                        r_oe    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_bit_cnt <= '0;
                    r_state   <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (r_ss_sync) begin
                        r_state     <= ST_IDLE;
                        r_oe        <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ur_pend   <= 1'b0;
                        r_frame_err <= (r_bit_cnt != '0);
                        r_bit_cnt   <= '0;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            if (r_bit_cnt == c_LAST) begin
                                r_bit_cnt  <= '0;
                                r_rxdata   <= w_rx_next;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        // An empty reload between words only counts once the
                        // master actually begins the next word.
                        if (w_sck_lead && w_first && r_ur_pend) begin
                            r_underrun <= 1'b1;
                            r_ur_pend  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_reload) begin
                r_tx_shift <= r_tx_full ? r_hold : '0;
                if (!r_tx_full) begin
                    if (r_state == ST_LOAD) begin
                        r_underrun <= 1'b1;
                    end else begin
                        r_ur_pend <= 1'b1;
                    end
                end
            end else if (w_tx_step) begin
                r_tx_shift <= r_tx_shift >> 1;
            end else if ((r_state == ST_ACTIVE) && r_ss_sync) begin
                r_tx_shift <= '0;
            end
        end
    end

    assign miso_o      = r_tx_shift[0];
    assign miso_oe_o   = r_oe;
    assign tx_full_o   = r_tx_full;
    assign rxdata_o    = r_rxdata;
    assign rx_valid_o  = r_rx_valid;
    assign busy_o      = r_busy;
    assign underrun_o  = r_underrun;
    assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire
